// File: rtl/snake_pkg.sv
// Shared types and constants for the snake tick sequencer and its tick generator.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WB   = 3'd2,
    RD   = 3'd3,
    RW   = 3'd4
  } seq_state_t;

  // snakeTracker register byte offsets
  localparam logic [3:0] REG_DIR    = 4'h0;
  localparam logic [3:0] REG_HEAD   = 4'h4;
  localparam logic [3:0] REG_LEN    = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  localparam logic [1:0] OKAY = 2'b00;

  // Opposite directions differ only in bit 1 (UP/DOWN, RIGHT/LEFT).
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game tick generator: free-running divide-by-TICK_DIV counter, one-cycle tick at wrap.
// Optional macro SNAKE_SEQ_PAUSE_EN adds a pause input that freezes the counter.
module snake_tick_gen
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SNAKE_SEQ_PAUSE_EN
  input  logic pause,
`endif
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          run;

`ifdef SNAKE_SEQ_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  assign tick = run && (cnt == LAST);

  // Count 0..TICK_DIV-1 and wrap; hold while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snake_tick_sequencer.sv
// AXI4-Lite master: once per game tick writes the committed direction to the
// snakeTracker DIR register, then reads HEAD and publishes head_x/head_y.
// Optional macro SNAKE_SEQ_PAUSE_EN adds a pause input that stops tick generation.
module snake_tick_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TICK_DIV           = 25_000_000,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
`ifdef SNAKE_SEQ_PAUSE_EN
  input  logic                          pause,
`endif
  input  dir_t                          dir_req,
  input  logic                          dir_req_vld,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [15:0]                   head_x,
  output logic [15:0]                   head_y,
  output logic                          head_vld,
  output logic                          busy,
  output logic                          axi_err,
  output logic                          tick_overrun
);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] DIR_ADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(REG_DIR);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] HEAD_ADDR = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(REG_HEAD);

  seq_state_t state;
  dir_t       pend_dir;
  dir_t       cmt_dir;
  dir_t       pend_nxt;
  logic       tick;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;
  assign busy         = (state != IDLE);

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (ACLK),
    .rst_n (ARESETN),
`ifdef SNAKE_SEQ_PAUSE_EN
    .pause (pause),
`endif
    .tick  (tick)
  );

  // Next pending direction: a request in the tick cycle still counts for that tick.
  always_comb begin
    pend_nxt = pend_dir;
    if (dir_req_vld && !is_reverse(dir_req, cmt_dir)) begin
      pend_nxt = dir_req;
    end
  end

  // Pending/committed direction; commit only on a tick that starts a sequence.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pend_dir <= RIGHT;
      cmt_dir  <= RIGHT;
    end else begin
      pend_dir <= pend_nxt;
      if (tick && state == IDLE) begin
        cmt_dir <= pend_nxt;
      end
    end
  end

  // Write-DIR / read-HEAD transaction sequencer with sticky status flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      head_x        <= '0;
      head_y        <= '0;
      head_vld      <= 1'b0;
      axi_err       <= 1'b0;
      tick_overrun  <= 1'b0;
    end else begin
      head_vld <= 1'b0;
      if (tick && state != IDLE) begin
        tick_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            M_AXI_AWADDR  <= DIR_ADDR;
            M_AXI_WDATA   <= {{(C_M_AXI_DATA_WIDTH-2){1'b0}}, pend_nxt};
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= WR;
          end
        end
        WR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          // A channel is done once its VALID has dropped or it handshakes now.
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WB;
          end
        end
        WB: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != OKAY) axi_err <= 1'b1;
            M_AXI_ARADDR  <= HEAD_ADDR;
            M_AXI_ARVALID <= 1'b1;
            state         <= RD;
          end
        end
        RD: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RW;
          end
        end
        RW: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            head_x       <= M_AXI_RDATA[15:0];
            head_y       <= M_AXI_RDATA[31:16];
            head_vld     <= 1'b1;
            if (M_AXI_RRESP != OKAY) axi_err <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_tick_sequencer.sv
// Directed bench for snake_tick_sequencer with a configurable AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_snake_tick_sequencer;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dir_t        dir_req;
  logic        dir_req_vld;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bready, bvalid;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic [15:0] head_x, head_y;
  logic        head_vld, busy, axi_err, tick_overrun;
`ifdef SNAKE_SEQ_PAUSE_EN
  logic        pause = 1'b0;
`endif

  snake_tick_sequencer #(
    .C_M_AXI_ADDR_WIDTH (4),
    .C_M_AXI_DATA_WIDTH (32),
    .TICK_DIV           (16),
    .BASE_ADDR          (4'h0)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
`ifdef SNAKE_SEQ_PAUSE_EN
    .pause         (pause),
`endif
    .dir_req       (dir_req),
    .dir_req_vld   (dir_req_vld),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .head_x        (head_x),
    .head_y        (head_y),
    .head_vld      (head_vld),
    .busy          (busy),
    .axi_err       (axi_err),
    .tick_overrun  (tick_overrun)
  );

  // ---------------- slave model ----------------
  int unsigned aw_wait = 0, ar_wait = 0, r_stall = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] head_reg = 32'h0003_0005;
  int unsigned aw_cnt, ar_cnt, r_cnt, wr_cnt, rd_cnt;
  logic        aw_got, w_got, r_pend;
  logic [3:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;

  assign awready = (aw_cnt >= aw_wait);
  assign wready  = 1'b1;
  assign arready = (ar_cnt >= ar_wait);
  assign rresp   = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0;
      wr_addr <= '1; rd_addr <= '1; wr_data <= '1;
    end else begin
      if (awvalid && awready) begin
        aw_cnt <= 0; aw_got <= 1'b1; wr_addr <= awaddr;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1; wr_data <= wdata;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid) begin
        bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0; wr_cnt <= wr_cnt + 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_cnt <= 0; rd_addr <= araddr; rd_cnt <= rd_cnt + 1; rdata <= head_reg;
        if (r_stall == 0) rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= r_stall - 1; end
      end else if (arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt - 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic        aw_prev = 1'b0, addr_bad = 1'b0, bready_early = 1'b0;
  logic [3:0]  aw_last = '0;
  int unsigned aw_rise_cyc = 0, aw_hi = 0, w_hi = 0, hv_cnt = 0, hv_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_prev = 1'b0;
    end else begin
      if (awvalid && !aw_prev) begin aw_rise_cyc = cyc; aw_hi = 0; w_hi = 0; end
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (awvalid && aw_prev && awaddr != aw_last) addr_bad = 1'b1;
      if (bready && (awvalid || wvalid)) bready_early = 1'b1;
      if (head_vld) begin hv_cnt++; hv_cyc = cyc; end
      aw_prev = awvalid;
      aw_last = awaddr;
    end
  end

  // ---------------- checking ----------------
  int unsigned vectors = 0, miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_head(input string tag);
    int unsigned n0;
    bit          seen;
    n0   = hv_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (hv_cnt != n0) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_dir(input dir_t d);
    dir_req = d; dir_req_vld = 1'b1;
    @(negedge clk);
    dir_req_vld = 1'b0;
  endtask

  int unsigned n_rd, prev_rise;
  bit          found;

  initial begin
    dir_req = RIGHT; dir_req_vld = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check_eq("rst_head", {head_y, head_x}, 32'd0);
    check_eq("rst_flags", 32'({head_vld, busy, axi_err, tick_overrun}), 32'd0);
    rst_n = 1'b1;

    // first sequence, zero-wait slave
    wait_head("seq1");
    check_eq("seq1_awaddr", 32'(wr_addr), 32'h0);
    check_eq("seq1_wdata", wr_data, 32'h1);
    check_eq("seq1_araddr", 32'(rd_addr), 32'h4);
    check_eq("seq1_head_x", 32'(head_x), 32'd5);
    check_eq("seq1_head_y", 32'(head_y), 32'd3);
    check_eq("seq1_aw_cyc", aw_rise_cyc, 32'd16);
    check_eq("seq1_hv_cyc", hv_cyc, 32'd20);
    check_eq("seq1_ties", 32'({awprot, arprot, wstrb}), 32'h00F);
    @(negedge clk); #1;
    check_eq("seq1_hv_pulse", 32'(head_vld), 32'd0);
    check_eq("seq1_idle", 32'(busy), 32'd0);

    // direction filtering against the committed direction
    pulse_dir(LEFT);
    wait_head("rev");
    check_eq("rev_rejected", wr_data, 32'h1);
    pulse_dir(UP); pulse_dir(LEFT);
    wait_head("up_left");
    check_eq("up_kept", wr_data, 32'h0);
    pulse_dir(LEFT);
    wait_head("left");
    check_eq("left_ok", wr_data, 32'h3);

    // request in the tick cycle counts for that tick
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (cyc % 16 == 15) found = 1'b1;
    end
    check_eq("tick_align", 32'(found), 32'd1);
    pulse_dir(DOWN);
    wait_head("same_tick");
    check_eq("same_tick_dir", wr_data, 32'h2);
    pulse_dir(UP);
    wait_head("up_rev");
    check_eq("up_rejected", wr_data, 32'h2);

    // AW stalled 3 cycles, W accepted at once
    aw_wait = 3;
    wait_head("aw_stall");
    aw_wait = 0;
    check_eq("aw_hold", aw_hi, 32'd4);
    check_eq("w_hold", w_hi, 32'd1);
    check_eq("aw_stable", 32'(addr_bad), 32'd0);
    check_eq("bready_order", 32'(bready_early), 32'd0);

    // error response is sticky, read still happens
    check_eq("err_clear", 32'(axi_err), 32'd0);
    bresp_cfg = 2'b10;
    n_rd = rd_cnt;
    wait_head("bresp");
    bresp_cfg = 2'b00;
    check_eq("err_set", 32'(axi_err), 32'd1);
    check_eq("err_read", rd_cnt, n_rd + 1);
    wait_head("after_err");
    check_eq("err_sticky", 32'(axi_err), 32'd1);

    // slow read overruns one tick
    check_eq("ovr_clear", 32'(tick_overrun), 32'd0);
    r_stall = 20;
    wait_head("stall");
    r_stall = 0;
    prev_rise = aw_rise_cyc;
    check_eq("ovr_set", 32'(tick_overrun), 32'd1);
    wait_head("post_stall");
    check_eq("ovr_next_tick", aw_rise_cyc - prev_rise, 32'd32);
    check_eq("ovr_sticky", 32'(tick_overrun), 32'd1);

    // reset while ARVALID is held in RD
    ar_wait = 1000;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (arvalid) found = 1'b1;
    end
    check_eq("rd_reached", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    check_eq("arst_flags", 32'({head_vld, busy, axi_err, tick_overrun}), 32'd0);
    check_eq("arst_head", {head_y, head_x}, 32'd0);
    ar_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_head("post_rst");
    check_eq("post_rst_dir", wr_data, 32'h1);
    check_eq("post_rst_cyc", aw_rise_cyc, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
